if_id_stage: RTL and testbench

//  IF/ID pipeline stage of the MIPS core: registers fetched instruction+PC, splits fields,

---
 rtl/if_id_stage.sv | 151 +++++++++++++++
 tb/tb_if_id_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: registers fetched instruction+PC, splits MIPS32 fields, flags zero-extend immediates.
// Latency: 1 cycle from accept to d_* when not stalled; optional macro IFID_PERF_CNT_EN adds perf_stall_cnt.
// Backpressure: 2-entry main+skid buffer; f_ready is registered and deasserts only while both entries are held.
module if_id_stage #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               f_valid,
  output logic               f_ready,
  input  logic [INSTR_W-1:0] f_instr,
  input  logic [PC_W-1:0]    f_pc,
  output logic               d_valid,
  input  logic               d_ready,
  output logic [INSTR_W-1:0] d_instr,
  output logic [PC_W-1:0]    d_pc,
  output logic [PC_W-1:0]    d_pc_plus4,
  output logic [5:0]         d_opcode,
  output logic [4:0]         d_rs,
  output logic [4:0]         d_rt,
  output logic [4:0]         d_rd,
  output logic [4:0]         d_shamt,
  output logic [5:0]         d_funct,
  output logic [15:0]        d_imm16,
  output logic               d_zext,
`ifdef IFID_PERF_CNT_EN
  output logic [25:0]        d_target,
  output logic [15:0]        perf_stall_cnt
`else
  output logic [25:0]        d_target
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_f_ready;
  logic               r_d_valid;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  logic w_in;
  logic w_out;

  assign w_in  = f_valid & r_f_ready;
  assign w_out = r_d_valid & d_ready;

  // Occupancy FSM: main register feeds decode, skid catches one extra word while f_ready is still high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_f_ready    <= 1'b1;
      r_d_valid    <= 1'b0;
      r_main_instr <= '0;
      r_main_pc    <= RESET_PC;
      r_skid_instr <= '0;
      r_skid_pc    <= RESET_PC;
    end else if (flush) begin
      // Flush wins over everything; the same-cycle fetch offer is dropped.
      r_state      <= ST_EMPTY;
      r_f_ready    <= 1'b1;
      r_d_valid    <= 1'b0;
      r_main_instr <= '0;
      r_main_pc    <= RESET_PC;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            r_main_instr <= f_instr;
            r_main_pc    <= f_pc;
            r_d_valid    <= 1'b1;
            r_state      <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_in && w_out) begin
            r_main_instr <= f_instr;
            r_main_pc    <= f_pc;
          end else if (w_out) begin
            // Main keeps its last value so outputs hold while idle.
            r_d_valid <= 1'b0;
            r_state   <= ST_EMPTY;
          end else if (w_in) begin
            r_skid_instr <= f_instr;
            r_skid_pc    <= f_pc;
            r_f_ready    <= 1'b0;
            r_state      <= ST_SKID;
          end
        end
        ST_SKID: begin
          // f_ready is low here, so nothing new arrives; skid moves up behind the departing main.
          if (w_out) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_f_ready    <= 1'b1;
            r_state      <= ST_FULL;
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          r_f_ready <= 1'b1;
          r_d_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of cycles where decode holds valid data that downstream refuses; flush does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_d_valid && !d_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
`endif

  logic [5:0] w_opcode;
  assign w_opcode = r_main_instr[31:26];

  assign f_ready    = r_f_ready;
  assign d_valid    = r_d_valid;
  assign d_instr    = r_main_instr;
  assign d_pc       = r_main_pc;
  assign d_pc_plus4 = r_main_pc + PC_W'(4);
  assign d_opcode   = w_opcode;
  assign d_rs       = r_main_instr[25:21];
  assign d_rt       = r_main_instr[20:16];
  assign d_rd       = r_main_instr[15:11];
  assign d_shamt    = r_main_instr[10:6];
  assign d_funct    = r_main_instr[5:0];
  assign d_imm16    = r_main_instr[15:0];
  assign d_target   = r_main_instr[25:0];
  // Logical immediates (andi/ori/xori) are zero-extended; everything else sign-extends.
  assign d_zext     = (w_opcode == 6'h0C) || (w_opcode == 6'h0D) || (w_opcode == 6'h0E);

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        f_valid;
  logic        f_ready;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc_plus4;
  logic [5:0]  d_opcode;
  logic [4:0]  d_rs, d_rt, d_rd, d_shamt;
  logic [5:0]  d_funct;
  logic [15:0] d_imm16;
  logic        d_zext;
  logic [25:0] d_target;
`ifdef IFID_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
`endif

  if_id_stage #(.PC_W(32), .INSTR_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .f_valid(f_valid), .f_ready(f_ready), .f_instr(f_instr), .f_pc(f_pc),
    .d_valid(d_valid), .d_ready(d_ready), .d_instr(d_instr), .d_pc(d_pc),
    .d_pc_plus4(d_pc_plus4), .d_opcode(d_opcode), .d_rs(d_rs), .d_rt(d_rt),
    .d_rd(d_rd), .d_shamt(d_shamt), .d_funct(d_funct), .d_imm16(d_imm16),
`ifdef IFID_PERF_CNT_EN
    .d_zext(d_zext), .d_target(d_target), .perf_stall_cnt(perf_stall_cnt)
`else
    .d_zext(d_zext), .d_target(d_target)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: an ordered list of at most two held words plus the word on display.
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t mq[$];
  ent_t shown;

  task automatic model_reset();
    mq.delete();
    shown = '{instr: 32'h0, pc: RST_PC};
  endtask

  // Called at a negedge: drive inputs, advance the model across the next posedge, return at next negedge.
  task automatic cyc(input logic fv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic dr, input logic fl);
    bit m_in, m_out;
    f_valid = fv; f_instr = ins; f_pc = pc; d_ready = dr; flush = fl;
    m_out = (mq.size() > 0) && dr;
    m_in  = fv && (mq.size() < 2);
    if (fl) begin
      mq.delete();
      shown = '{instr: 32'h0, pc: RST_PC};
    end else begin
      if (m_out) void'(mq.pop_front());
      if (m_in) mq.push_back('{instr: ins, pc: pc});
      if (mq.size() > 0) shown = mq[0];
    end
    @(negedge clk);
  endtask

  task automatic cmp_model(input string tag);
    logic [31:0] i;
    bit          zx;
    i  = shown.instr;
    zx = (i[31:26] == 6'h0C) || (i[31:26] == 6'h0D) || (i[31:26] == 6'h0E);
    chk({tag, "_ctrl"}, {126'h0, d_valid, f_ready}, {126'h0, mq.size() > 0, mq.size() < 2});
    chk({tag, "_data"}, {32'h0, d_instr, d_pc, d_pc_plus4}, {32'h0, i, shown.pc, shown.pc + 32'd4});
    chk({tag, "_fields"},
        {53'h0, d_opcode, d_rs, d_rt, d_rd, d_shamt, d_funct, d_imm16, d_zext, d_target},
        {53'h0, i[31:26], i[25:21], i[20:16], i[15:11], i[10:6], i[5:0], i[15:0], zx, i[25:0]});
  endtask

  typedef struct {
    logic [31:0] instr; logic [31:0] pc;
    logic [5:0] op; logic [4:0] rs, rt, rd, sh; logic [5:0] fn;
    logic [15:0] imm; logic zx; logic [25:0] tgt; logic [31:0] p4;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] got[$];
  logic [31:0] exp_seq[3];
  bit          sent3;
  bit          acc;

  initial begin
    vecs[0] = '{32'h2008_FFFF, 32'h0000_0100, 6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b0, 26'h008_FFFF, 32'h0000_0104};
    vecs[1] = '{32'h3421_8000, 32'h0000_0200, 6'h0D, 5'd1, 5'd1, 5'd16, 5'd0, 6'h00, 16'h8000, 1'b1, 26'h021_8000, 32'h0000_0204};
    vecs[2] = '{32'h0043_0820, 32'hFFFF_FFFC, 6'h00, 5'd2, 5'd3, 5'd1, 5'd0, 6'h20, 16'h0820, 1'b0, 26'h043_0820, 32'h0000_0000};
    vecs[3] = '{32'h3083_00FF, 32'h0000_0300, 6'h0C, 5'd4, 5'd3, 5'd0, 5'd3, 6'h3F, 16'h00FF, 1'b1, 26'h083_00FF, 32'h0000_0304};
    vecs[4] = '{32'h3C01_1234, 32'h0000_0400, 6'h0F, 5'd0, 5'd1, 5'd2, 5'd8, 6'h34, 16'h1234, 1'b0, 26'h001_1234, 32'h0000_0404};
    vecs[5] = '{32'h3BFF_FFFF, 32'hFFFF_FFF8, 6'h0E, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b1, 26'h3FF_FFFF, 32'hFFFF_FFFC};

    rst_n = 1'b0; flush = 1'b0; f_valid = 1'b0; f_instr = '0; f_pc = '0; d_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", {38'h0, d_valid, f_ready, d_pc, d_instr, d_imm16, d_zext, d_opcode},
        {38'h0, 1'b0, 1'b1, RST_PC, 32'h0, 16'h0, 1'b0, 6'h0});
`ifdef IFID_PERF_CNT_EN
    chk("perf_reset", {112'h0, perf_stall_cnt}, 128'h0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single-instruction decode checks.
    foreach (vecs[k]) begin
      cyc(1'b1, vecs[k].instr, vecs[k].pc, 1'b1, 1'b0);
      chk($sformatf("vec%0d", k),
          {21'h0, d_valid, d_opcode, d_rs, d_rt, d_rd, d_shamt, d_funct, d_imm16, d_zext, d_target, d_pc_plus4},
          {21'h0, 1'b1, vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].rd, vecs[k].sh, vecs[k].fn,
           vecs[k].imm, vecs[k].zx, vecs[k].tgt, vecs[k].p4});
      cmp_model($sformatf("vec%0d_m", k));
      cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      cmp_model($sformatf("vec%0d_idle", k));
    end

    // Streaming at full throughput: one new word on d_* every cycle.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 32'h2000_0000 + k, 32'h100 + 4 * k, 1'b1, 1'b0);
      chk($sformatf("stream%0d", k), {95'h0, d_valid, d_pc}, {95'h0, 1'b1, 32'h100 + 4 * k});
    end
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cmp_model("stream_end");

    // Backpressure: three back-to-back words while downstream is stalled.
    exp_seq[0] = 32'h1111_0001; exp_seq[1] = 32'h2222_0002; exp_seq[2] = 32'h3333_0003;
    cyc(1'b1, exp_seq[0], 32'h10, 1'b0, 1'b0);
    cyc(1'b1, exp_seq[1], 32'h14, 1'b0, 1'b0);
    chk("bp_f_ready_low", {127'h0, f_ready}, 128'h0);
    cyc(1'b1, exp_seq[2], 32'h18, 1'b0, 1'b0);
    chk("bp_hold_main", {95'h0, d_valid, d_instr}, {95'h0, 1'b1, exp_seq[0]});
    cmp_model("bp_skid");
    got.delete();
    sent3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (d_valid) got.push_back(d_instr);
      acc = f_ready && !sent3;
      cyc(!sent3, exp_seq[2], 32'h18, 1'b1, 1'b0);
      if (acc) sent3 = 1'b1;
    end
    chk("bp_count", {96'h0, got.size()}, 128'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("bp_order%0d", k), {96'h0, (k < got.size()) ? got[k] : 32'hDEAD_BEEF}, {96'h0, exp_seq[k]});
    cmp_model("bp_end");

    // Flush while both entries are held and fetch is offering.
    cyc(1'b1, 32'hAAAA_0001, 32'h40, 1'b0, 1'b0);
    cyc(1'b1, 32'hAAAA_0002, 32'h44, 1'b0, 1'b0);
    cmp_model("fl_pre");
    cyc(1'b1, 32'hBBBB_0003, 32'h48, 1'b0, 1'b1);
    chk("flush_out", {62'h0, d_valid, f_ready, d_instr, d_pc}, {62'h0, 1'b0, 1'b1, 32'h0, RST_PC});
    cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_not_taken", {127'h0, d_valid}, 128'h0);

    // Asynchronous reset in the middle of a stalled stream.
    cyc(1'b1, 32'hCCCC_0001, 32'h80, 1'b0, 1'b0);
    cyc(1'b1, 32'hCCCC_0002, 32'h84, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset", {78'h0, d_valid, f_ready, d_pc, d_imm16},
        {78'h0, 1'b0, 1'b1, RST_PC, 16'h0});
    model_reset();
    f_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cmp_model("post_reset");

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] ri;
      ri = $urandom;
      if ($urandom_range(0, 3) == 0) ri[31:26] = 6'(6'h0C + $urandom_range(0, 3));
      cyc($urandom_range(0, 3) != 0, ri, $urandom, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0);
      cmp_model($sformatf("rnd%0d", k));
    end

`ifdef IFID_PERF_CNT_EN
    cyc(1'b1, 32'h0800_0001, 32'h0, 1'b0, 1'b0);
    f_valid = 1'b0;
    repeat (70000) @(negedge clk);
    chk("perf_saturate", {112'h0, perf_stall_cnt}, {112'h0, 16'hFFFF});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
